// File: rtl/sync_counter.sv
// Free-running binary up-counter, width Size bits, wrapping modulo 2**Size.
// Synchronous active-high reset takes priority over counting.
module sync_counter #(
  parameter int Size = 5
) (
  input  logic            clock,
  input  logic            reset,
  output logic [Size-1:0] count
);

  logic [Size-1:0] cnt_q;

  // The increment stays at Size bits, so the carry out of the MSB drops and the count wraps.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_q + Size'(1);
  end

  assign count = cnt_q;

endmodule

// File: tb/tb_sync_counter.sv
// Directed bench for sync_counter: three instances (Size 5, 1, 8) share one clock and reset.
module tb_sync_counter;

  logic       clock;
  logic       reset;
  logic [4:0] c5;
  logic [0:0] c1;
  logic [7:0] c8;

  int checks = 0;
  int errors = 0;

  sync_counter #(.Size(5)) u_c5 (.clock(clock), .reset(reset), .count(c5));
  sync_counter #(.Size(1)) u_c1 (.clock(clock), .reset(reset), .count(c1));
  sync_counter #(.Size(8)) u_c8 (.clock(clock), .reset(reset), .count(c8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int edges);
    reset = 1'b1;
    for (int i = 0; i < edges; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;

    // Reset held two edges keeps every width at zero.
    tick();
    chk("rst_e1_c5", 32'(c5), 32'd0);
    chk("rst_e1_c1", 32'(c1), 32'd0);
    chk("rst_e1_c8", 32'(c8), 32'd0);
    tick();
    chk("rst_e2_c5", 32'(c5), 32'd0);
    chk("rst_e2_c1", 32'(c1), 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_c5", 32'(c5), 32'd1);
    chk("rel_c8", 32'(c8), 32'd1);

    // Size 1 toggles: 0 after reset, then 1, 0, 1.
    chk("s1_a", 32'(c1), 32'd1);
    tick();
    chk("s1_b", 32'(c1), 32'd0);
    chk("s1_b_c5", 32'(c5), 32'd2);
    tick();
    chk("s1_c", 32'(c1), 32'd1);
    chk("s1_c_c5", 32'(c5), 32'd3);

    // Ten edges after reset, each sample one above the last.
    do_reset(1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("inc_step", 32'(c5), 32'(i));
    end
    chk("inc_10", 32'(c5), 32'b01010);

    // Wrap: 31 -> 0 -> 1.
    do_reset(1);
    for (int i = 0; i < 31; i++) tick();
    chk("wrap_31", 32'(c5), 32'b11111);
    tick();
    chk("wrap_0", 32'(c5), 32'd0);
    tick();
    chk("wrap_1", 32'(c5), 32'd1);

    // Mid-count reset at 17, then resume 1, 2, 3.
    do_reset(1);
    for (int i = 0; i < 17; i++) tick();
    chk("mid_17", 32'(c5), 32'd17);
    do_reset(1);
    chk("mid_rst", 32'(c5), 32'd0);
    tick();
    chk("mid_r1", 32'(c5), 32'd1);
    tick();
    chk("mid_r2", 32'(c5), 32'd2);
    tick();
    chk("mid_r3", 32'(c5), 32'd3);

    // Reset at all-ones, held three edges.
    do_reset(1);
    for (int i = 0; i < 31; i++) tick();
    chk("pri_31", 32'(c5), 32'd31);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pri_hold", 32'(c5), 32'd0);
      chk("pri_hold_c8", 32'(c8), 32'd0);
    end
    reset = 1'b0;

    // Size 8 runs 255 edges to all-ones, then wraps; Size 5 wraps along the way.
    for (int i = 1; i <= 255; i++) begin
      tick();
      chk("s8_step", 32'(c8), 32'(i));
      chk("s8_c5", 32'(c5), 32'(i % 32));
    end
    chk("s8_255", 32'(c8), 32'd255);
    tick();
    chk("s8_wrap", 32'(c8), 32'd0);
    chk("s8_wrap_c5", 32'(c5), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
